// File: rtl/icache_pkg.sv
// Shared types and defaults for the instruction-cache refill path.
// instr_at() is the single definition of the MSB-first line layout.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    SETTLE
  } refill_state_t;

  localparam int DATAW_DEF    = 16;
  localparam int INW_DEF      = 512;
  localparam int ADDRW_DEF    = 32;
  localparam int NUMINSTR_DEF = INW_DEF / DATAW_DEF;
  localparam int TIMEOUT_DEF  = 256;

  // Instruction k of a line sits at base+2k and occupies the k-th chunk counted from the MSB end.
  function automatic logic [DATAW_DEF-1:0] instr_at(input logic [INW_DEF-1:0] line,
                                                    input int unsigned k);
    logic [INW_DEF-1:0] w_shifted;
    w_shifted = line << (k * DATAW_DEF);
    return w_shifted[INW_DEF-1 -: DATAW_DEF];
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: stalls fetch, issues one line read,
// and writes the returned line into the cache for a single cycle.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int INW            = INW_DEF,
  parameter int ADDRW          = ADDRW_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [ADDRW-1:0] pc_in,
  input  logic             cache_valid,
  input  logic             flush,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [ADDRW-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [INW-1:0]   mem_rsp_data,
  output logic             cache_write,
  output logic [ADDRW-1:0] cache_base_addr,
  output logic [INW-1:0]   cache_data,
  output logic             stall,
  output logic [15:0]      refill_count,
  output logic             timeout_err
);

  localparam int CNTW = $clog2(TIMEOUT_CYCLES) + 1;

  refill_state_t    r_state;
  refill_state_t    w_next;
  logic [ADDRW-1:0] r_miss_addr;
  logic [ADDRW-1:0] r_base;
  logic [INW-1:0]   r_line;
  logic [CNTW-1:0]  r_tcnt;
  logic             r_discard;
  logic [15:0]      r_refill_count;
  logic             r_timeout_err;

  logic w_miss;
  logic w_accept;
  logic w_rsp;
  logic w_timeout;

  // Gating with rst_n keeps stall low while reset is held even if fetch is requesting.
  assign w_miss    = rst_n && fetch_req && !cache_valid && !flush;
  assign w_accept  = (r_state == REQ) && mem_req_ready;
  assign w_rsp     = (r_state == WAIT) && mem_rsp_valid;
  assign w_timeout = (r_state == WAIT) && !mem_rsp_valid &&
                     (r_tcnt == CNTW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    mem_req_valid = 1'b0;
    cache_write   = 1'b0;
    stall         = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_miss;
        if (w_miss) w_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        stall         = !r_discard;
        if (mem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        stall = !r_discard;
        if (mem_rsp_valid) w_next = r_discard ? IDLE : FILL;
        else if (w_timeout) w_next = REQ;
      end
      FILL: begin
        cache_write = 1'b1;
        stall       = !r_discard;
        w_next      = SETTLE;
      end
      SETTLE: begin
        stall  = !r_discard;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_addr    <= '0;
      r_base         <= '0;
      r_line         <= '0;
      r_tcnt         <= '0;
      r_discard      <= 1'b0;
      r_refill_count <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_miss) r_miss_addr <= pc_in & ~ADDRW'(1);

      if (w_accept)               r_tcnt <= '0;
      else if (r_state == WAIT)   r_tcnt <= r_tcnt + 1'b1;

      // Base and line are captured together so both hold their last written values outside FILL.
      if (w_rsp && !r_discard) begin
        r_line <= mem_rsp_data;
        r_base <= r_miss_addr;
      end

      if (w_rsp)                                           r_discard <= 1'b0;
      else if (flush && (r_state == REQ || r_state == WAIT)) r_discard <= 1'b1;

      if (w_timeout) r_timeout_err <= 1'b1;

      if ((r_state == FILL) && (r_refill_count != 16'hFFFF))
        r_refill_count <= r_refill_count + 16'd1;
    end
  end

  assign mem_req_addr    = r_miss_addr;
  assign cache_base_addr = r_base;
  assign cache_data      = r_line;
  assign refill_count    = r_refill_count;
  assign timeout_err     = r_timeout_err;

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-handling / fill side of the instruction cache.
- Watches the fetch address and the cache's valid_out. On a miss, stalls fetch and issues a single line read to the memory interface.
- Captures the returned INW-bit line and drives the cache's write, base_addr_in and data_in ports for one cycle.
- Sits between the fetch stage, InstructionCache and the host memory request port.

Parameters:
- DATAW, 16, instruction width in bits
- INW, 512, line width in bits; NUMINSTRUCTIONS = INW/DATAW
- ADDRW, 32, byte address width
- TIMEOUT_CYCLES, 256, maximum cycles to wait for a memory response before retry

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch stage wants the instruction at pc_in this cycle
- pc_in  in  ADDRW  fetch byte address (halfword aligned)
- cache_valid  in  1  InstructionCache valid_out for pc_in
- flush  in  1  redirect; cancel any outstanding miss
- mem_req_valid  out  1  line read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDRW  line start byte address
- mem_rsp_valid  in  1  line data valid (single beat)
- mem_rsp_data  in  INW  returned line
- cache_write  out  1  to InstructionCache write
- cache_base_addr  out  ADDRW  to InstructionCache base_addr_in
- cache_data  out  INW  to InstructionCache data_in
- stall  out  1  hold fetch stage
- refill_count  out  16  completed refills, saturating
- timeout_err  out  1  sticky: at least one response timeout occurred

Behaviour:
- Reset (async, rst_n=0) state:
  - state=IDLE, miss_addr=0, line register=0, timeout counter=0, discard=0.
  - All outputs 0, including refill_count and timeout_err.
- States: IDLE, REQ, WAIT, FILL, SETTLE.
- IDLE:
  - Miss = fetch_req && !cache_valid && !flush.
  - stall is combinational: 1 on a miss, else 0.
  - On a miss: miss_addr <= {pc_in[ADDRW-1:1],1'b0} (bit 0 forced low), then go to REQ.
- REQ:
  - mem_req_valid=1; mem_req_addr=miss_addr, held stable until accepted.
  - On mem_req_valid && mem_req_ready: go to WAIT, timeout counter <= 0.
  - mem_req_valid is never withdrawn once raised, even on flush.
- WAIT:
  - Timeout counter increments each cycle.
  - On mem_rsp_valid: if discard=0, latch the line and go to FILL; if discard=1, drop the data, clear discard, go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response: timeout_err <= 1 (sticky until reset), go back to REQ and retry the same address.
  - A late response arriving in REQ is ignored.
- FILL (exactly 1 cycle):
  - cache_write=1, cache_base_addr=miss_addr, cache_data=line register.
  - refill_count <= refill_count+1, saturating at 16'hFFFF. Go to SETTLE.
- SETTLE (1 cycle): allows the cache to register the line and valid_out to update. Go to IDLE.
- Line ordering:
  - The line is written verbatim; no reordering.
  - The instruction at byte address base+2k is cache_data[INW-1-k*DATAW -: DATAW], i.e. MSB chunk first.
  - The line covers base through base+2*(NUMINSTRUCTIONS-1). The base need not be line-aligned.
- Stall timing:
  - stall=1 in REQ, WAIT, FILL and SETTLE whenever discard=0.
  - First valid fetch is the cycle after SETTLE, i.e. 3 cycles after the response if memory answers immediately.
- flush:
  - In IDLE: suppresses the miss.
  - In REQ or WAIT: sets discard=1 and drops stall; the outstanding request/response completes and is discarded, with no cache write.
  - In FILL or SETTLE: ignored; the write completes (harmless, still a valid line).
- While discard=1, new misses are not accepted until back in IDLE.
- cache_base_addr and cache_data hold their last values outside FILL; cache_write=0 outside FILL.

Decomposition:
- Package icache_pkg holds:
  - state enum refill_state_t {IDLE, REQ, WAIT, FILL, SETTLE}
  - DATAW/INW/ADDRW defaults
  - function instr_at(line, k) returning the k-th instruction (MSB-first), shared with the cache and benches.
- No sub-module needed. The timeout counter and saturating refill counter are in-line.

Test Plan:
- Basic miss:
  - Stimulus: fetch_req=1, pc_in=0x100, cache_valid=0; mem_req_ready=1 immediately; response 2 cycles later with a random line L.
  - Required: mem_req_addr=0x100 for exactly 1 handshake; cache_write high for 1 cycle with base 0x100, data L; stall low the cycle after SETTLE; refill_count=1.
- Unaligned base:
  - Stimulus: pc_in=50 (0x32).
  - Required: cache_base_addr=50; a model cache returns L[511:496] at addr 50 and L[495:480] at 52; addr 48 reads invalid.
- Backpressure:
  - Stimulus: mem_req_ready low for 5 cycles.
  - Required: mem_req_valid stays 1 and mem_req_addr stays stable; exactly one request accepted.
- Flush in WAIT:
  - Stimulus: flush pulse 1 cycle after acceptance; response arrives later.
  - Required: stall drops the cycle after the flush; no cache_write; refill_count unchanged; state returns to IDLE.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, no response.
  - Required: timeout_err=1 after 8 cycles in WAIT; second request to the same address; response then completes the fill normally.
- Reset mid-WAIT:
  - Stimulus: rst_n=0 asynchronously.
  - Required: all outputs 0 immediately (no clock edge needed); after release, state=IDLE.
